// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic array operand path.
//   ARRAY_SIZE     : default array dimension (lanes per edge)
//   DATA_WIDTH     : default operand width (BF16 bit pattern)
//   K_WIDTH        : default width of the job length field
//   DRAIN_CYCLES   : cycles needed to flush the skew lines and the array
//   feeder_state_t : operand feeder sequencer states
// -----------------------------------------------------------------------------
package systolic_pkg;

   localparam int ARRAY_SIZE   = 32;
   localparam int DATA_WIDTH   = 16;
   localparam int K_WIDTH      = 16;
   localparam int DRAIN_CYCLES = 2 * ARRAY_SIZE;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      FEED  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } feeder_state_t;

endpackage

// File: rtl/skew_delay_line.sv
// -----------------------------------------------------------------------------
// skew_delay_line
// Shift register of DEPTH stages used to skew one operand lane. The line only
// moves when adv is high, so a stalled array and its operand wavefront freeze
// together.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, zeroes every stage
//   clr   : synchronous clear, zeroes every stage
//   adv   : shift enable
//   din   : word entering stage 0
//   dout  : last stage (registered)
// -----------------------------------------------------------------------------
module skew_delay_line #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             adv,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage_reg [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_reg[i] <= '0;
         end
      end else if (clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_reg[i] <= '0;
         end
      end else if (adv) begin
         stage_reg[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            stage_reg[i] <= stage_reg[i-1];
         end
      end
   end

   assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/systolic_operand_feeder.sv
// -----------------------------------------------------------------------------
// systolic_operand_feeder
// Sequencer and skew generator for the operand edge of the output-stationary
// systolic array. Accepts one k-slice per beat (column k of A, row k of B),
// emits diagonally skewed wavefronts, owns the array en/clear_acc for the
// whole job, then drains the pipeline and pulses done.
// Optional feature: define FEEDER_STATS_EN to build the stall counter;
// otherwise stat_stall_cycles is tied to zero.
// Ports:
//   clk, rst_n         : clock (rising edge), asynchronous active-low reset
//   start, cfg_k       : job request and length, sampled only in IDLE
//   busy, done         : job in progress, one-cycle end-of-job pulse
//   s_valid, s_ready   : upstream slice handshake
//   s_a, s_b           : A column k / B row k, lane l in bits [l*DATA_WIDTH +: DATA_WIDTH]
//   arr_en             : array enable
//   arr_clear_acc      : array accumulator clear
//   arr_a_col          : skewed A operands for the top edge
//   arr_b_row          : skewed B operands for the left edge
//   stat_stall_cycles  : FEED cycles with s_valid low
// -----------------------------------------------------------------------------
module systolic_operand_feeder
   import systolic_pkg::*;
#(
   parameter int ARRAY_SIZE = systolic_pkg::ARRAY_SIZE,
   parameter int DATA_WIDTH = systolic_pkg::DATA_WIDTH,
   parameter int K_WIDTH    = systolic_pkg::K_WIDTH
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic [K_WIDTH-1:0]               cfg_k,
   output logic                             busy,
   output logic                             done,
   input  logic                             s_valid,
   output logic                             s_ready,
   input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] s_a,
   input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] s_b,
   output logic                             arr_en,
   output logic                             arr_clear_acc,
   output logic [ARRAY_SIZE*DATA_WIDTH-1:0] arr_a_col,
   output logic [ARRAY_SIZE*DATA_WIDTH-1:0] arr_b_row,
   output logic [31:0]                      stat_stall_cycles
);

   // Drain length tracks the instance's own ARRAY_SIZE (equals DRAIN_CYCLES at
   // the package default): enough for the deepest skew line plus the array.
   localparam int DRAIN_LEN = 2 * ARRAY_SIZE;
   localparam int DRAIN_W   = $clog2(DRAIN_LEN);
   localparam int VEC_W     = ARRAY_SIZE * DATA_WIDTH;

   feeder_state_t        state_reg;
   logic [K_WIDTH-1:0]   k_len_reg;
   logic [K_WIDTH-1:0]   slice_cnt_reg;
   logic [DRAIN_W-1:0]   drain_cnt_reg;
   logic                 busy_reg;
   logic                 done_reg;
   logic                 clear_reg;

   logic                 feed_state;
   logic                 drain_state;
   logic                 adv;
   logic [VEC_W-1:0]     a_din;
   logic [VEC_W-1:0]     b_din;

   // ---------------------------------------------------------------------
   // Sequencer. busy/done/clear are registered alongside the state so they
   // are exact decodes of the state register.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         k_len_reg     <= '0;
         slice_cnt_reg <= '0;
         drain_cnt_reg <= '0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         clear_reg     <= 1'b0;
      end else begin
         done_reg  <= 1'b0;
         clear_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  k_len_reg     <= cfg_k;
                  slice_cnt_reg <= '0;
                  drain_cnt_reg <= '0;
                  busy_reg      <= 1'b1;
                  clear_reg     <= 1'b1;
                  state_reg     <= CLEAR;
               end
            end
            CLEAR: begin
               if (k_len_reg != '0) begin
                  state_reg <= FEED;
               end else begin
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
               end
            end
            FEED: begin
               if (s_valid) begin
                  slice_cnt_reg <= slice_cnt_reg + K_WIDTH'(1);
                  // k_len is nonzero here, so k_len-1 never underflows and
                  // the counter stops before it could wrap.
                  if (slice_cnt_reg == k_len_reg - K_WIDTH'(1)) begin
                     state_reg <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               drain_cnt_reg <= drain_cnt_reg + DRAIN_W'(1);
               if (drain_cnt_reg == DRAIN_W'(DRAIN_LEN - 1)) begin
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
               end
            end
            DONE: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign feed_state  = (state_reg == FEED);
   assign drain_state = (state_reg == DRAIN);

   // The array and the skew lines advance on the same condition, so a stall
   // freezes both and the wavefront alignment survives any backpressure.
   assign adv           = (feed_state && s_valid) || drain_state;
   assign arr_en        = adv;
   assign s_ready       = feed_state;
   assign busy          = busy_reg;
   assign done          = done_reg;
   assign arr_clear_acc = clear_reg;

   // Zero words are inserted while draining; live data only in FEED.
   assign a_din = feed_state ? s_a : '0;
   assign b_din = feed_state ? s_b : '0;

   // ---------------------------------------------------------------------
   // Skew lines: lane l of each edge is delayed by l+1 stages.
   // ---------------------------------------------------------------------
   for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
      skew_delay_line #(
         .DEPTH (gi + 1),
         .WIDTH (DATA_WIDTH)
      ) u_skew_a (
         .clk   (clk),
         .rst_n (rst_n),
         .clr   (clear_reg),
         .adv   (adv),
         .din   (a_din[gi*DATA_WIDTH +: DATA_WIDTH]),
         .dout  (arr_a_col[gi*DATA_WIDTH +: DATA_WIDTH])
      );

      skew_delay_line #(
         .DEPTH (gi + 1),
         .WIDTH (DATA_WIDTH)
      ) u_skew_b (
         .clk   (clk),
         .rst_n (rst_n),
         .clr   (clear_reg),
         .adv   (adv),
         .din   (b_din[gi*DATA_WIDTH +: DATA_WIDTH]),
         .dout  (arr_b_row[gi*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   // ---------------------------------------------------------------------
   // Stall statistics
   // ---------------------------------------------------------------------
`ifdef FEEDER_STATS_EN
   logic [31:0] stall_cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_reg <= '0;
      end else if ((state_reg == IDLE) && start) begin
         // Cleared on the edge that enters CLEAR; held after done.
         stall_cnt_reg <= '0;
      end else if (feed_state && !s_valid && (stall_cnt_reg != '1)) begin
         stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
   end

   assign stat_stall_cycles = stall_cnt_reg;
`else
   assign stat_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_operand_feeder
// Driver pushes every accepted slice (and the drain zeros) into history
// queues; an independent monitor checks the skewed outputs after each
// advancing edge against that history, plus job-level timing checks.
// -----------------------------------------------------------------------------
module tb_systolic_operand_feeder;

   localparam int N     = 32;
   localparam int DW    = 16;
   localparam int KW    = 16;
   localparam int VW    = N * DW;
   localparam int DRAIN = 2 * N;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic [KW-1:0] cfg_k = '0;
   logic          busy;
   logic          done;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [VW-1:0] s_a = '0;
   logic [VW-1:0] s_b = '0;
   logic          arr_en;
   logic          arr_clear_acc;
   logic [VW-1:0] arr_a_col;
   logic [VW-1:0] arr_b_row;
   logic [31:0]   stat_stall_cycles;

   systolic_operand_feeder dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .start             (start),
      .cfg_k             (cfg_k),
      .busy              (busy),
      .done              (done),
      .s_valid           (s_valid),
      .s_ready           (s_ready),
      .s_a               (s_a),
      .s_b               (s_b),
      .arr_en            (arr_en),
      .arr_clear_acc     (arr_clear_acc),
      .arr_a_col         (arr_a_col),
      .arr_b_row         (arr_b_row),
      .stat_stall_cycles (stat_stall_cycles)
   );

   always #5 clk = ~clk;

   // Scoreboard state
   logic [VW-1:0] hist_a[$];
   logic [VW-1:0] hist_b[$];
   int            checks = 0;
   int            failures = 0;
   int            adv_m = 0;
   logic          en_last = 1'b0;
   int            done_pulses = 0;
   int            en_cnt = 0;
   int            clr_cnt = 0;
   int            done0, en0, clr0;
   logic          ready_err;
   logic [VW-1:0] ea, eb;

   // ---------------------------------------------------------------------
   // Monitor: after the m-th advancing edge of a job, lane j must show the
   // slice pushed at advancing edge m-j (zero before the job's first beat).
   // ---------------------------------------------------------------------
   always @(negedge clk) begin
      if (!rst_n) begin
         en_last = 1'b0;
      end else begin
         if (en_last) begin
            int first;
            adv_m++;
            for (int j = 0; j < N; j++) begin
               int idx;
               idx = adv_m - 1 - j;
               if (idx < 0) begin
                  ea[j*DW +: DW] = '0;
                  eb[j*DW +: DW] = '0;
               end else if (idx < hist_a.size()) begin
                  ea[j*DW +: DW] = hist_a[idx][j*DW +: DW];
                  eb[j*DW +: DW] = hist_b[idx][j*DW +: DW];
               end else begin
                  ea[j*DW +: DW] = 16'hDEAD;
                  eb[j*DW +: DW] = 16'hDEAD;
               end
            end
            checks++;
            if (arr_a_col !== ea || arr_b_row !== eb) begin
               failures++;
               first = 0;
               for (int j = N - 1; j >= 0; j--) begin
                  if (arr_a_col[j*DW +: DW] !== ea[j*DW +: DW] ||
                      arr_b_row[j*DW +: DW] !== eb[j*DW +: DW]) first = j;
               end
               $display("FAIL skew adv=%0d lane=%0d a=%h req_a=%h b=%h req_b=%h",
                        adv_m, first, arr_a_col[first*DW +: DW], ea[first*DW +: DW],
                        arr_b_row[first*DW +: DW], eb[first*DW +: DW]);
            end
         end
         if (arr_en === 1'b1)        en_cnt++;
         if (arr_clear_acc === 1'b1) clr_cnt++;
         if (done === 1'b1)          done_pulses++;
         en_last = (arr_en === 1'b1);
      end
   end

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic logic [15:0] rnd_bf16();
      case ($urandom_range(7))
         0: return 16'h3F80;   // 1.0
         1: return 16'h4000;   // 2.0
         2: return 16'h4040;   // 3.0
         3: return 16'hC080;   // -4.0
         4: return 16'h40A0;   // 5.0
         5: return 16'hC0C0;   // -6.0
         6: return 16'h4100;   // 8.0
         default: return 16'hBF80; // -1.0
      endcase
   endfunction

   // mode 0: A slice is column beat of the identity; mode 1: random A.
   function automatic logic [VW-1:0] gen_slice(input int mode, input int beat, input bit is_a);
      logic [VW-1:0] v;
      for (int j = 0; j < N; j++) begin
         if (mode == 0 && is_a) v[j*DW +: DW] = (j == beat) ? 16'h3F80 : 16'h0000;
         else                   v[j*DW +: DW] = rnd_bf16();
      end
      return v;
   endfunction

   // Runs one job starting in the current cycle (called at posedge+#1).
   // Returns at the negedge of the done cycle, or right after asserting
   // reset when abort_cycle is reached.
   task automatic run_job(input int k, input int mode, input int stall_pct,
                          input int bs1, input int bs2, input int abort_cycle,
                          output int done_cyc, output int stalls);
      int  beats;
      int  limit;
      bit  feed;
      hist_a.delete();
      hist_b.delete();
      adv_m     = 0;
      done0     = done_pulses;
      en0       = en_cnt;
      clr0      = clr_cnt;
      ready_err = 1'b0;
      stalls    = 0;
      beats     = 0;
      done_cyc  = -1;
      limit     = 2 * k + 200;
      cfg_k = KW'(k);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cfg_k = 16'hFFFF;
      for (int c = 1; c <= limit; c++) begin
         feed  = (c >= 2) && (beats < k);
         start = (c == bs1) || (c == bs2);
         cfg_k = start ? 16'd7 : 16'hFFFF;
         if (feed) begin
            if ($urandom_range(99) < stall_pct) begin
               s_valid = 1'b0;
               stalls++;
            end else begin
               s_valid = 1'b1;
               s_a = gen_slice(mode, beats, 1'b1);
               s_b = gen_slice(mode, beats, 1'b0);
            end
         end else begin
            // Junk offered outside FEED must never be consumed.
            s_valid = 1'($urandom_range(1));
            s_a = gen_slice(1, 0, 1'b1);
            s_b = gen_slice(1, 0, 1'b0);
         end
         if (c == abort_cycle) begin
            rst_n = 1'b0;
            break;
         end
         @(negedge clk);
         if (c == 1) check("busy_in_clear", busy, 1);
         if (s_ready !== feed) ready_err = 1'b1;
         if (feed && s_valid) begin
            hist_a.push_back(s_a);
            hist_b.push_back(s_b);
            beats++;
            if (beats == k) begin
               for (int d = 0; d < DRAIN; d++) begin
                  hist_a.push_back('0);
                  hist_b.push_back('0);
               end
            end
         end
         if (done === 1'b1) begin
            done_cyc = c;
            break;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      s_valid = 1'b0;
   endtask

   task automatic finish_job(input int k, input int dc, input int st);
      check("done_cycle", dc, (k == 0) ? 2 : k + 66 + st);
      @(posedge clk); #1;
      check("done_pulses", done_pulses - done0, 1);
      check("adv_edges", en_cnt - en0, (k == 0) ? 0 : k + DRAIN);
      check("clear_pulses", clr_cnt - clr0, 1);
      check("ready_window", ready_err, 0);
      check("busy_after_done", busy, 0);
`ifdef FEEDER_STATS_EN
      check("stall_stat", stat_stall_cycles, st);
`else
      check("stall_stat_tied", stat_stall_cycles, 0);
`endif
      $display("job k=%0d stalls=%0d done_cycle=%0d", k, st, dc);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_s_ready"}, s_ready, 0);
      check({tag, "_arr_en"}, arr_en, 0);
      check({tag, "_clear_acc"}, arr_clear_acc, 0);
      check({tag, "_a_col_zero"}, (arr_a_col === '0), 1);
      check({tag, "_b_row_zero"}, (arr_b_row === '0), 1);
      check({tag, "_stat"}, stat_stall_cycles, 0);
   endtask

   initial begin
      int dc, st;
      #1 rst_n = 1'b0;
      #11;
      check_reset_outputs("reset");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Identity A, random B, no stalls: done in cycle 98.
      run_job(32, 0, 0, 0, 0, 0, dc, st);
      finish_job(32, dc, st);

      // Random ~30% stalls in FEED.
      run_job(32, 0, 30, 0, 0, 0, dc, st);
      finish_job(32, dc, st);

      // Zero-length job.
      run_job(0, 1, 0, 0, 0, 0, dc, st);
      finish_job(0, dc, st);

      // Start pulses during FEED (cycle 5) and DRAIN (cycle 40) are ignored.
      run_job(8, 1, 0, 5, 40, 0, dc, st);
      finish_job(8, dc, st);

      // Reset at drain cycle 20: FEED is cycles 2..33, DRAIN starts at 34.
      run_job(32, 1, 0, 0, 0, 2 + 32 + 20, dc, st);
      #1;
      check_reset_outputs("midreset");
      @(negedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("no_done_after_reset", done_pulses - done0, 0);
      run_job(4, 1, 0, 0, 0, 0, dc, st);
      finish_job(4, dc, st);

      // Back-to-back: second start in the cycle right after done.
      run_job(3, 1, 0, 0, 0, 0, dc, st);
      finish_job(3, dc, st);
      run_job(5, 1, 20, 0, 0, 0, dc, st);
      finish_job(5, dc, st);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
